// File: rtl/key_debounce_multi_pkg.sv
// Shared constants and helpers for the multi-key debouncer.
// Defaults assume a 50 MHz pixel clock, a 20 ms debounce window and 500 ms / 100 ms auto-repeat.
package key_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int REPEAT_DLY_MS = 500;
    localparam int REPEAT_PER_MS = 100;

    localparam int CNT_MAX_DEF    = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int REPEAT_DLY_DEF = (CLK_FREQ_HZ / 1000) * REPEAT_DLY_MS;
    localparam int REPEAT_PER_DEF = (CLK_FREQ_HZ / 1000) * REPEAT_PER_MS;

    localparam int NUM_KEYS_MAX = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key bundle between the pins/consumer side (master) and the debouncer (slave).
interface key_debounce_multi_if #(
    parameter int NUM_KEYS = 4
);

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                key_any;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_any
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_any
    );

endinterface

// File: rtl/key_debounce_multi_ch.sv
// One debounced key channel: synchroniser, window counter, level and edge pulses.
// Auto-repeat of key_press is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int REPEAT_PER = REPEAT_PER_DEF
`endif
) (
    input  logic lcd_pclk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CW = $clog2(CNT_MAX + 1);

    logic          s0;
    logic          s1;
    logic [CW-1:0] cnt;
    logic          level_d;
    logic          level_next;
    logic          rep_fire;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            s0 <= key_in;
            s1 <= s0;
        end
    end

    // Any disagreement between the two sync stages restarts the stability window.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (s0 != s1) begin
            cnt <= CW'(CNT_MAX);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        level_next = key_level;
        if ((cnt == CW'(1)) && (s1 != key_level)) begin
            level_next = s1;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            key_level <= 1'b1;
            level_d   <= 1'b1;
        end else begin
            key_level <= level_next;
            level_d   <= key_level;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DLY, REPEAT_PER) + 1);

    logic [RW-1:0] rep_cnt;

    // Looking at level_next lets a release kill a repeat that would fire on the same edge.
    assign rep_fire = ~level_next & ~key_level & (rep_cnt == RW'(1));

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (level_next) begin
            rep_cnt <= '0;
        end else if (key_level) begin
            rep_cnt <= RW'(REPEAT_DLY);
        end else if (rep_fire) begin
            rep_cnt <= RW'(REPEAT_PER);
        end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= (level_d & ~key_level) | rep_fire;
            key_release <= ~level_d & key_level;
        end
    end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel active-low key debouncer with press/release pulses and an any-key flag.
// Define KEY_REPEAT_EN to add per-channel auto-repeat on held keys.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int CNT_MAX    = CNT_MAX_DEF,
    parameter int REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic                 lcd_pclk,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  bus
);

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] release_p;

    if ((NUM_KEYS < 1) || (NUM_KEYS > NUM_KEYS_MAX) || (CNT_MAX < 2) ||
        (REPEAT_DLY < 1) || (REPEAT_PER < 1)) begin : g_bad_param
        $error("key_debounce_multi: illegal parameter value");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX    (CNT_MAX)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
`endif
        ) u_ch (
            .lcd_pclk    (lcd_pclk),
            .rst_n       (rst_n),
            .key_in      (bus.key_in[i]),
            .key_level   (level[i]),
            .key_press   (press[i]),
            .key_release (release_p[i])
        );
    end

    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = release_p;
    assign bus.key_any     = |(~level);

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with CNT_MAX=10, REPEAT_DLY=30, REPEAT_PER=8.
// Edge numbers count rising edges after an input change; the first sampling edge is edge 1.
module tb_key_debounce_multi;

    logic lcd_pclk = 1'b0;
    logic rst_n    = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 lcd_pclk = ~lcd_pclk;

    key_debounce_multi_if #(.NUM_KEYS(4)) bus ();

    key_debounce_multi #(
        .NUM_KEYS   (4),
        .CNT_MAX    (10),
        .REPEAT_DLY (30),
        .REPEAT_PER (8)
    ) dut (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_in = 4'b0000;
        repeat (3) @(posedge lcd_pclk);
        #1;
        checks++;
        if (bus.key_level !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL reset_level got %b expected 1111", bus.key_level);
        end
        checks++;
        if (bus.key_press !== 4'b0000 || bus.key_release !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_pulses got press=%b release=%b expected 0000/0000", bus.key_press, bus.key_release);
        end
        checks++;
        if (bus.key_any !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_any got %b expected 0", bus.key_any);
        end
        @(negedge lcd_pclk);
        bus.key_in = 4'b1111;
        repeat (2) @(negedge lcd_pclk);
        rst_n = 1'b1;
        repeat (15) @(posedge lcd_pclk);
        #1;
        checks++;
        if (bus.key_level !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL post_reset_level got %b expected 1111", bus.key_level);
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_level, exp_press, exp_release;
        logic       exp_any;
        @(negedge lcd_pclk);
        bus.key_in[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge lcd_pclk);
            #1;
            exp_level = (e >= 12) ? 4'b1110 : 4'b1111;
            exp_press = (e == 13) ? 4'b0001 : 4'b0000;
            exp_any   = (e >= 12);
            checks++;
            if (bus.key_level !== exp_level) begin
                failures++;
                $display("[TB] FAIL press_level edge %0d got %b expected %b", e, bus.key_level, exp_level);
            end
            checks++;
            if (bus.key_press !== exp_press || bus.key_release !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL press_pulse edge %0d got press=%b release=%b expected %b/0000", e, bus.key_press, bus.key_release, exp_press);
            end
            checks++;
            if (bus.key_any !== exp_any) begin
                failures++;
                $display("[TB] FAIL press_any edge %0d got %b expected %b", e, bus.key_any, exp_any);
            end
        end
        @(negedge lcd_pclk);
        bus.key_in[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge lcd_pclk);
            #1;
            exp_level   = (e >= 12) ? 4'b1111 : 4'b1110;
            exp_release = (e == 13) ? 4'b0001 : 4'b0000;
            exp_any     = (e < 12);
            checks++;
            if (bus.key_level !== exp_level || bus.key_any !== exp_any) begin
                failures++;
                $display("[TB] FAIL release_level edge %0d got %b any=%b expected %b any=%b", e, bus.key_level, bus.key_any, exp_level, exp_any);
            end
            checks++;
            if (bus.key_release !== exp_release || bus.key_press !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL release_pulse edge %0d got release=%b press=%b expected %b/0000", e, bus.key_release, bus.key_press, exp_release);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_level, exp_press;
        for (int t = 0; t < 2; t++) begin
            @(negedge lcd_pclk);
            bus.key_in[1] = t[0];
            for (int k = 1; k <= 3; k++) begin
                @(posedge lcd_pclk);
                #1;
                checks++;
                if (bus.key_level !== 4'b1111 || bus.key_press !== 4'b0000 || bus.key_release !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL bounce_early toggle %0d edge %0d got level=%b press=%b release=%b expected 1111/0000/0000", t, k, bus.key_level, bus.key_press, bus.key_release);
                end
            end
        end
        @(negedge lcd_pclk);
        bus.key_in[1] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge lcd_pclk);
            #1;
            exp_level = (e >= 12) ? 4'b1101 : 4'b1111;
            exp_press = (e == 13) ? 4'b0010 : 4'b0000;
            checks++;
            if (bus.key_level !== exp_level || bus.key_press !== exp_press || bus.key_release !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL bounce_settle edge %0d got level=%b press=%b release=%b expected %b/%b/0000", e, bus.key_level, bus.key_press, bus.key_release, exp_level, exp_press);
            end
        end
        @(negedge lcd_pclk);
        bus.key_in[1] = 1'b1;
        repeat (20) @(posedge lcd_pclk);
        #1;
        checks++;
        if (bus.key_level !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL bounce_restore got %b expected 1111", bus.key_level);
        end
    endtask

    task automatic test_glitch();
        @(negedge lcd_pclk);
        bus.key_in[2] = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge lcd_pclk);
            #1;
            checks++;
            if (bus.key_level !== 4'b1111 || bus.key_press !== 4'b0000 || bus.key_release !== 4'b0000 || bus.key_any !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch edge %0d got level=%b press=%b release=%b any=%b expected 1111/0000/0000/0", e, bus.key_level, bus.key_press, bus.key_release, bus.key_any);
            end
            if (e == 9) begin
                @(negedge lcd_pclk);
                bus.key_in[2] = 1'b1;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_level, exp_press, exp_release;
        @(negedge lcd_pclk);
        bus.key_in = 4'b0110;
        for (int e = 1; e <= 20; e++) begin
            @(posedge lcd_pclk);
            #1;
            exp_level = (e >= 12) ? 4'b0110 : 4'b1111;
            exp_press = (e == 13) ? 4'b1001 : 4'b0000;
            checks++;
            if (bus.key_level !== exp_level || bus.key_press !== exp_press || bus.key_release !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL simul_press edge %0d got level=%b press=%b release=%b expected %b/%b/0000", e, bus.key_level, bus.key_press, bus.key_release, exp_level, exp_press);
            end
        end
        @(negedge lcd_pclk);
        bus.key_in[3] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge lcd_pclk);
            #1;
            exp_level   = (e >= 12) ? 4'b1110 : 4'b0110;
            exp_release = (e == 13) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.key_level !== exp_level || bus.key_release !== exp_release || bus.key_press !== 4'b0000 || bus.key_any !== 1'b1) begin
                failures++;
                $display("[TB] FAIL simul_release edge %0d got level=%b release=%b press=%b any=%b expected %b/%b/0000/1", e, bus.key_level, bus.key_release, bus.key_press, bus.key_any, exp_level, exp_release);
            end
        end
        @(negedge lcd_pclk);
        bus.key_in[0] = 1'b1;
        repeat (20) @(posedge lcd_pclk);
        #1;
        checks++;
        if (bus.key_level !== 4'b1111 || bus.key_any !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_restore got level=%b any=%b expected 1111/0", bus.key_level, bus.key_any);
        end
    endtask

    task automatic test_reset_mid_window();
        logic [3:0] exp_level, exp_press;
        @(negedge lcd_pclk);
        bus.key_in[0] = 1'b0;
        // After edge 7 the key 0 window counter sits at 5.
        repeat (7) @(posedge lcd_pclk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.key_level !== 4'b1111 || bus.key_press !== 4'b0000 || bus.key_release !== 4'b0000 || bus.key_any !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got level=%b press=%b release=%b any=%b expected 1111/0000/0000/0", bus.key_level, bus.key_press, bus.key_release, bus.key_any);
        end
        repeat (2) @(negedge lcd_pclk);
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge lcd_pclk);
            #1;
            exp_level = (e >= 12) ? 4'b1110 : 4'b1111;
            exp_press = (e == 13) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.key_level !== exp_level || bus.key_press !== exp_press || bus.key_release !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL midreset_press edge %0d got level=%b press=%b release=%b expected %b/%b/0000", e, bus.key_level, bus.key_press, bus.key_release, exp_level, exp_press);
            end
        end
        @(negedge lcd_pclk);
        bus.key_in[0] = 1'b1;
        repeat (20) @(posedge lcd_pclk);
        #1;
        checks++;
        if (bus.key_level !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL midreset_restore got %b expected 1111", bus.key_level);
        end
    endtask

    task automatic test_repeat();
        logic exp_press, exp_release, exp_level;
        @(negedge lcd_pclk);
        bus.key_in[0] = 1'b0;
        for (int e = 1; e <= 110; e++) begin
            @(posedge lcd_pclk);
            #1;
`ifdef KEY_REPEAT_EN
            exp_press = (e == 13) || (e == 42) || (e == 50) || (e == 58) || (e == 66) || (e == 74);
`else
            exp_press = (e == 13);
`endif
            exp_release = (e == 79);
            exp_level   = !((e >= 12) && (e < 78));
            checks++;
            if (bus.key_press[0] !== exp_press) begin
                failures++;
                $display("[TB] FAIL repeat_press edge %0d got %b expected %b", e, bus.key_press[0], exp_press);
            end
            checks++;
            if (bus.key_release[0] !== exp_release || bus.key_level[0] !== exp_level) begin
                failures++;
                $display("[TB] FAIL repeat_level edge %0d got release=%b level=%b expected %b/%b", e, bus.key_release[0], bus.key_level[0], exp_release, exp_level);
            end
            if (e == 66) begin
                @(negedge lcd_pclk);
                bus.key_in[0] = 1'b1;
            end
        end
    endtask

    initial begin
        bus.key_in = 4'b1111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_window();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog timeout got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
